// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 8-bit CPU control path: sequencer state
// encoding, opcode values, the instruction field layout and the
// branch-offset sign-extension helper used by the next-PC adder.
package cpu_pkg;

    localparam int WORD_W   = 8;
    localparam int BR_OFF_W = 6;

    // Sequencer state encoding (3-bit, visible on the debug port).
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ALU   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_BRZ   = 2'b11
    } op_t;

    // Instruction layout: op[7:6] ra[5:4] rb[3:2] func[1:0].
    // BRZ reuses ra/rb/func together as a signed 6-bit offset.
    typedef struct packed {
        op_t        op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] func;
    } instr_t;

    function automatic logic [WORD_W-1:0] sext_off(input logic [BR_OFF_W-1:0] off);
        return {{(WORD_W-BR_OFF_W){off[BR_OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
// Single shared memory port with a ready handshake.
//   mem_req    request (held until mem_ready)
//   mem_we     write qualifier for mem_req
//   mem_addr   request address
//   mem_ready  memory completes the request this cycle
//   mem_rdata  read data, valid with mem_ready
// master: the sequencer; slave: the memory.
interface cpu_sequencer_if;
    import cpu_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/cpu_sequencer_pc_next.sv
// cpu_sequencer_pc_next
// Next-PC adder: pc + 1 for sequential fetch, or pc + sign-extended
// 6-bit offset for a taken branch. Wraps modulo 256.
//   pc       current program counter
//   offset   BRZ offset field
//   branch   1 = add offset, 0 = increment
//   pc_nxt   resulting program counter
module cpu_sequencer_pc_next
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0]   pc,
    input  logic [BR_OFF_W-1:0] offset,
    input  logic                branch,
    output logic [WORD_W-1:0]   pc_nxt
);

    assign pc_nxt = pc + (branch ? sext_off(offset) : WORD_W'(1));

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle instruction sequencer: owns pc, ir and the zero flag and
// steps each instruction through fetch/decode/execute/memory/writeback
// over one shared memory port.
//   clk, rst     system clock, async active-high reset
//   run          level enable, sampled in IDLE and at completion
//   data_addr    load/store address from the datapath
//   alu_zero     ALU zero result, valid in EXEC
//   bus          memory port (master side)
//   ir, pc       instruction register, program counter
//   alu_en       ALU result capture strobe
//   reg_write    register-file write strobe
//   mem_to_reg   writeback source: 1 = memory, 0 = ALU
//   instr_done   pulse on the last cycle of each instruction
//   state        current FSM state (debug)
//
// state  | meaning
// IDLE   | stopped, waiting for run
// FETCH  | read instruction at pc, hold until mem_ready
// DECODE | one cycle for the datapath to decode ir
// EXEC   | ALU capture / branch resolve / route to MEM
// MEM    | data access at data_addr, hold until mem_ready
// WB     | register-file write, ALU or memory source
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_RESET = 8'h00
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [WORD_W-1:0] data_addr,
    input  logic              alu_zero,
    cpu_sequencer_if.master   bus,
    output logic [WORD_W-1:0] ir,
    output logic [WORD_W-1:0] pc,
    output logic              alu_en,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              instr_done,
    output logic [2:0]        state
);

    state_t            state_q, state_d;
    instr_t            ir_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_nxt;
    logic              zero_flag;
    logic              ir_load;
    logic              pc_load;
    logic              pc_branch;
    logic              zf_load;
    state_t            done_next;

    assign ir    = ir_q;
    assign pc    = pc_q;
    assign state = state_q;

    // Completion is the only point besides IDLE where run is looked at.
    assign done_next = run ? ST_FETCH : ST_IDLE;

    cpu_sequencer_pc_next u_pc_next (
        .pc     (pc_q),
        .offset ({ir_q.ra, ir_q.rb, ir_q.func}),
        .branch (pc_branch),
        .pc_nxt (pc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            zero_flag <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_load)
                ir_q <= instr_t'(bus.mem_rdata);
            if (pc_load)
                pc_q <= pc_nxt;
            if (zf_load)
                zero_flag <= alu_zero;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        alu_en       = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        instr_done   = 1'b0;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        pc_branch    = 1'b0;
        zf_load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run)
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = pc_q;
                if (bus.mem_ready) begin
                    ir_load = 1'b1;
                    pc_load = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (ir_q.op)
                    OP_ALU: begin
                        alu_en  = 1'b1;
                        zf_load = 1'b1;
                        state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        state_d = ST_MEM;
                    end
                    default: begin
                        // BRZ: pc already points past the branch.
                        pc_branch  = 1'b1;
                        pc_load    = zero_flag;
                        instr_done = 1'b1;
                        state_d    = done_next;
                    end
                endcase
            end
            ST_MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = data_addr;
                bus.mem_we   = (ir_q.op == OP_STORE);
                if (bus.mem_ready) begin
                    if (ir_q.op == OP_STORE) begin
                        instr_done = 1'b1;
                        state_d    = done_next;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (ir_q.op == OP_LOAD);
                instr_done = 1'b1;
                state_d    = done_next;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] data_addr = 8'h00;
    logic       alu_zero = 1'b0;

    logic [7:0] ir, pc;
    logic       alu_en, reg_write, mem_to_reg, instr_done;
    logic [2:0] state;

    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;
    int req_seen;

    cpu_sequencer_if bus ();

    assign bus.mem_ready = rdy;
    assign bus.mem_rdata = mem[bus.mem_addr];

    cpu_sequencer #(.PC_RESET(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .data_addr  (data_addr),
        .alu_zero   (alu_zero),
        .bus        (bus),
        .ir         (ir),
        .pc         (pc),
        .alu_en     (alu_en),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h06;   // ALU
        mem[8'h01] = 8'h44;   // LOAD
        mem[8'h02] = 8'h98;   // STORE
        mem[8'h03] = 8'h00;   // ALU
        mem[8'h04] = 8'hCB;   // BRZ +11 -> 10
        mem[8'h10] = 8'hFE;   // BRZ -2
        mem[8'h0F] = 8'h00;   // ALU
        mem[8'h11] = 8'h00;   // ALU
        mem[8'h12] = 8'hEB;   // BRZ -21 -> FE
        mem[8'hFE] = 8'hC2;   // BRZ +2 (pc FF -> 01)
        mem[8'h80] = 8'h5A;

        // reset values
        #1;
        chk("rst_pc", pc, 8'h00);
        chk("rst_state", {5'd0, state}, 8'd0);
        chk("rst_ir", ir, 8'h00);
        chk("rst_req", {7'd0, bus.mem_req}, 8'd0);
        chk("rst_addr", bus.mem_addr, 8'h00);
        chk("rst_done", {7'd0, instr_done}, 8'd0);
        tick();
        tick();
        rst = 1'b0;

        // run=0: no requests for 20 cycles
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.mem_req) req_seen++;
        end
        chk("idle_no_req", 8'(req_seen), 8'd0);
        chk("idle_state", {5'd0, state}, 8'd0);

        // ALU at 00, zero-wait
        run = 1'b1; rdy = 1'b1; alu_zero = 1'b0;
        tick();
        chk("alu_c1_state", {5'd0, state}, 8'd1);
        chk("alu_c1_req", {7'd0, bus.mem_req}, 8'd1);
        chk("alu_c1_addr", bus.mem_addr, 8'h00);
        chk("alu_c1_we", {7'd0, bus.mem_we}, 8'd0);
        tick();
        chk("alu_c2_state", {5'd0, state}, 8'd2);
        chk("alu_c2_ir", ir, 8'h06);
        chk("alu_c2_pc", pc, 8'h01);
        chk("alu_c2_req", {7'd0, bus.mem_req}, 8'd0);
        tick();
        chk("alu_c3_alu_en", {7'd0, alu_en}, 8'd1);
        chk("alu_c3_rw", {7'd0, reg_write}, 8'd0);
        run = 1'b0;
        tick();
        chk("alu_c4_state", {5'd0, state}, 8'd5);
        chk("alu_c4_rw", {7'd0, reg_write}, 8'd1);
        chk("alu_c4_m2r", {7'd0, mem_to_reg}, 8'd0);
        chk("alu_c4_done", {7'd0, instr_done}, 8'd1);
        chk("alu_c4_pc", pc, 8'h01);
        chk("alu_c4_alu_en", {7'd0, alu_en}, 8'd0);
        tick();
        chk("alu_idle_state", {5'd0, state}, 8'd0);
        chk("alu_idle_done", {7'd0, instr_done}, 8'd0);

        // LOAD at 01 with two MEM wait cycles
        data_addr = 8'h80; run = 1'b1; rdy = 1'b1;
        tick();
        chk("ld_c1_addr", bus.mem_addr, 8'h01);
        tick();
        chk("ld_c2_ir", ir, 8'h44);
        chk("ld_c2_pc", pc, 8'h02);
        rdy = 1'b0;
        tick();
        chk("ld_c3_state", {5'd0, state}, 8'd3);
        chk("ld_c3_req", {7'd0, bus.mem_req}, 8'd0);
        tick();
        chk("ld_c4_state", {5'd0, state}, 8'd4);
        chk("ld_c4_addr", bus.mem_addr, 8'h80);
        chk("ld_c4_we", {7'd0, bus.mem_we}, 8'd0);
        tick();
        chk("ld_c5_state", {5'd0, state}, 8'd4);
        chk("ld_c5_addr", bus.mem_addr, 8'h80);
        chk("ld_c5_req", {7'd0, bus.mem_req}, 8'd1);
        tick();
        rdy = 1'b1;
        chk("ld_c6_state", {5'd0, state}, 8'd4);
        chk("ld_c6_addr", bus.mem_addr, 8'h80);
        chk("ld_c6_done", {7'd0, instr_done}, 8'd0);
        tick();
        chk("ld_c7_state", {5'd0, state}, 8'd5);
        chk("ld_c7_rw", {7'd0, reg_write}, 8'd1);
        chk("ld_c7_m2r", {7'd0, mem_to_reg}, 8'd1);
        chk("ld_c7_done", {7'd0, instr_done}, 8'd1);
        tick();
        chk("b2b_state", {5'd0, state}, 8'd1);
        chk("b2b_addr", bus.mem_addr, 8'h02);

        // STORE at 02
        data_addr = 8'h33;
        chk("st_c1_rw", {7'd0, reg_write}, 8'd0);
        tick();
        chk("st_c2_ir", ir, 8'h98);
        chk("st_c2_rw", {7'd0, reg_write}, 8'd0);
        tick();
        chk("st_c3_rw", {7'd0, reg_write}, 8'd0);
        tick();
        chk("st_c4_state", {5'd0, state}, 8'd4);
        chk("st_c4_req", {7'd0, bus.mem_req}, 8'd1);
        chk("st_c4_we", {7'd0, bus.mem_we}, 8'd1);
        chk("st_c4_addr", bus.mem_addr, 8'h33);
        chk("st_c4_done", {7'd0, instr_done}, 8'd1);
        chk("st_c4_rw", {7'd0, reg_write}, 8'd0);
        tick();
        chk("st_next_state", {5'd0, state}, 8'd1);
        chk("st_next_pc", pc, 8'h03);

        // ALU at 03 sets zero flag
        alu_zero = 1'b1;
        tick(); tick();
        chk("alu2_alu_en", {7'd0, alu_en}, 8'd1);
        tick();
        alu_zero = 1'b0;
        tick();
        chk("alu2_pc", pc, 8'h04);

        // BRZ at 04, taken -> 10, 3-cycle latency
        tick();
        chk("brz1_d_pc", pc, 8'h05);
        tick();
        chk("brz1_e_state", {5'd0, state}, 8'd3);
        chk("brz1_e_done", {7'd0, instr_done}, 8'd1);
        chk("brz1_e_alu_en", {7'd0, alu_en}, 8'd0);
        tick();
        chk("brz1_tgt_pc", pc, 8'h10);
        chk("brz1_tgt_addr", bus.mem_addr, 8'h10);

        // BRZ FE at 10, zero flag still set -> 0F
        tick(); tick(); tick();
        chk("brz_taken_pc", pc, 8'h0F);

        // ALU at 0F clears zero flag
        tick(); tick(); tick(); tick();
        chk("alu3_pc", pc, 8'h10);

        // BRZ FE at 10, not taken -> 11
        tick(); tick(); tick();
        chk("brz_nt_pc", pc, 8'h11);
        chk("brz_nt_state", {5'd0, state}, 8'd1);

        // ALU at 11 sets zero flag, BRZ at 12 -> FE
        alu_zero = 1'b1;
        tick(); tick(); tick();
        alu_zero = 1'b0;
        tick();
        tick(); tick(); tick();
        chk("brz_fe_pc", pc, 8'hFE);

        // BRZ +2 at FE: pc FF in EXEC, wraps to 01
        tick();
        chk("wrap_d_pc", pc, 8'hFF);
        tick(); tick();
        chk("wrap_pc", pc, 8'h01);

        // LOAD at 01, run dropped during DECODE
        data_addr = 8'h80;
        tick();
        run = 1'b0;
        chk("rd_d_state", {5'd0, state}, 8'd2);
        tick();
        chk("rd_e_state", {5'd0, state}, 8'd3);
        tick();
        chk("rd_m_state", {5'd0, state}, 8'd4);
        tick();
        chk("rd_w_done", {7'd0, instr_done}, 8'd1);
        chk("rd_w_rw", {7'd0, reg_write}, 8'd1);
        tick();
        chk("rd_idle_state", {5'd0, state}, 8'd0);
        tick();
        chk("rd_idle2_req", {7'd0, bus.mem_req}, 8'd0);
        run = 1'b1;
        tick();
        chk("rd_resume_state", {5'd0, state}, 8'd1);
        chk("rd_resume_addr", bus.mem_addr, 8'h02);

        // STORE at 02 stalled in MEM, then reset
        data_addr = 8'h40;
        tick(); tick();
        rdy = 1'b0;
        tick();
        tick();
        chk("rm_mem_state", {5'd0, state}, 8'd4);
        chk("rm_mem_req", {7'd0, bus.mem_req}, 8'd1);
        rst = 1'b1;
        #1;
        chk("rm_pc", pc, 8'h00);
        chk("rm_state", {5'd0, state}, 8'd0);
        chk("rm_req", {7'd0, bus.mem_req}, 8'd0);
        chk("rm_addr", bus.mem_addr, 8'h00);
        chk("rm_ir", ir, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 8-bit CPU. It owns the program counter, instruction register and zero flag. It steps each instruction through fetch/decode/execute/memory/writeback over a single shared memory port with a ready handshake, and emits per-cycle strobes that sequence the register file, ALU and memory.

## Interface
Parameters:
- `PC_RESET`, 8'h00, PC value loaded on reset.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level enable; sampled only in IDLE and at instruction completion.
- `mem_ready`  in  1  memory completes the current request this cycle (may be combinational from `mem_req`).
- `mem_rdata`  in  8  memory read data, valid when `mem_ready`=1.
- `data_addr`  in  8  load/store address from the datapath (register `rb`).
- `alu_zero`  in  1  ALU result-is-zero, valid during EXEC.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `mem_addr`  out  8  `pc` in FETCH, `data_addr` in MEM, else 0.
- `ir`  out  8  instruction register.
- `pc`  out  8  program counter.
- `alu_en`  out  1  ALU result capture strobe.
- `reg_write`  out  1  register-file write strobe.
- `mem_to_reg`  out  1  writeback source select: 1 = memory data, 0 = ALU.
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `state`  out  3  current FSM state, for debug.

## Operation
- Instruction fields:
  - `ir[7:6]` = op (00 ALU, 01 LOAD, 10 STORE, 11 BRZ)
  - `ir[5:4]` = ra, `ir[3:2]` = rb, `ir[1:0]` = func
  - BRZ offset is `ir[5:0]`, signed.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Codes 6 and 7 go to IDLE.
- IDLE: all strobes low. Go to FETCH when `run`=1.
- FETCH:
  - `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - Stays in FETCH until `mem_ready`.
  - On `mem_ready`: `ir` <= `mem_rdata`, `pc` <= `pc`+1 (mod 256, FF wraps to 00), go to DECODE.
- DECODE: one cycle, no strobes. Go to EXEC.
- EXEC:
  - op 00: `alu_en`=1, `zero_flag` <= `alu_zero`, go to WB.
  - op 01 or 10: go to MEM.
  - op 11: if `zero_flag`=1, `pc` <= `pc` + sign-extended `ir[5:0]` (pc already incremented, mod 256). Instruction complete.
- MEM:
  - `mem_req`=1, `mem_addr`=`data_addr`, `mem_we`=(op==10).
  - Stays in MEM until `mem_ready`.
  - On `mem_ready`: LOAD goes to WB; STORE completes.
- WB: `reg_write`=1 for exactly one cycle, `mem_to_reg`=(op==01). Instruction complete.
- On completion:
  - `instr_done`=1 in that cycle.
  - Next state is FETCH if `run`=1, else IDLE.
  - `run` is ignored mid-instruction: an issued `mem_req` is never withdrawn before `mem_ready`.
- `zero_flag` is internal. Only ALU instructions update it; LOAD, STORE and BRZ leave it unchanged.

## Timing
- Reset values (async, immediate on `rst`):
  - state=IDLE, `pc`=`PC_RESET`, `ir`=0, `zero_flag`=0.
  - All strobes (`mem_req`, `mem_we`, `alu_en`, `reg_write`, `instr_done`) = 0; `mem_to_reg`=0; `mem_addr`=0.
- Reset mid-operation abandons any outstanding request. Memory must tolerate `mem_req` dropping without `mem_ready`.
- All outputs are Moore-decoded from state and `ir`, except `instr_done`, which depends on `run`-independent completion only.
- Latency with zero-wait memory (`mem_ready`=1 in the first request cycle):
  - ALU 4 cycles (F,D,E,W)
  - LOAD 5 cycles (F,D,E,M,W)
  - STORE 4 cycles (F,D,E,M)
  - BRZ 3 cycles (F,D,E)
- Each wait cycle in FETCH or MEM adds one cycle.
- Back-to-back instructions with `run`=1: the FETCH of the next instruction follows the completion cycle with no bubble.
- `pc` increments in the FETCH-accept cycle. A taken branch's target is visible on `pc` in the cycle after EXEC.

## Structure
- Shared package `cpu_pkg` holds:
  - state encoding constants (3-bit);
  - opcode constants OP_ALU, OP_LOAD, OP_STORE, OP_BRZ;
  - instruction field widths and positions.
- Single module, no sub-module required. The next-PC adder (increment or branch offset) may be factored as `pc_next` if reused by a later pipelined core.

## Test plan
- Reset/idle: assert `rst` mid-MEM with `mem_req`=1 → next observation shows `pc`=00, state=0, `mem_req`=0. With `run`=0 after reset → no `mem_req` for 20 cycles.
- ALU timing: memory returns 8'h06 at addr 00, zero-wait → `alu_en` on cycle 3, `reg_write`=1 with `mem_to_reg`=0 on cycle 4, `instr_done` on cycle 4, `pc`=01.
- LOAD with wait states: `ir`=8'h44, `data_addr`=8'h80, `mem_ready` delayed 2 cycles in MEM:
  - `mem_addr`=80 and `mem_we`=0 held for 3 cycles;
  - then `reg_write`=1 with `mem_to_reg`=1;
  - total 7 cycles.
- STORE: `ir`=8'h98 → `mem_req`=1, `mem_we`=1, `mem_addr`=`data_addr`; `reg_write` never asserts; total 4 cycles.
- BRZ:
  - Taken: ALU with `alu_zero`=1, then BRZ `ir`=8'hFE at `pc`=10 → `pc`=0F after EXEC.
  - Not taken: `alu_zero`=0 → `pc`=11.
  - Wrap: BRZ offset +2 at `pc`=FF → `pc`=01.
- `run` deassert: drop `run` during DECODE → instruction completes normally, then IDLE. `run` re-asserted → FETCH from the next `pc`.
